apuf_eval_ctrl: RTL

- Sequencer for the arbiter-PUF delay line.
- Accepts a challenge over a valid/ready handshake and holds it on the delay-line challenge inputs.
- Fires NUM_EVALS launch pulses into the line and samples the arbiter output after each one.
- Returns a majority-voted response bit, the ones count and an instability flag over a valid/ready handshake. Sits between the host/UART command logic and the delay line plus arbiter latch.

---
 rtl/apuf_eval_ctrl_if.sv | 37 +++
 rtl/apuf_eval_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/apuf_eval_ctrl_if.sv
// Host-side handshake bundle for the arbiter-PUF evaluation sequencer:
// the challenge request channel and the voted response channel.
interface apuf_eval_ctrl_if #(
  parameter int LINE_LENGTH = 3,
  parameter int CW          = 3
);
  logic                   chal_valid;
  logic                   chal_ready;
  logic [LINE_LENGTH-1:0] chal_in;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_bit;
  logic [CW-1:0]          resp_ones;
  logic                   resp_unstable;

  modport master (
    output chal_valid,
    output chal_in,
    output resp_ready,
    input  chal_ready,
    input  resp_valid,
    input  resp_bit,
    input  resp_ones,
    input  resp_unstable
  );

  modport slave (
    input  chal_valid,
    input  chal_in,
    input  resp_ready,
    output chal_ready,
    output resp_valid,
    output resp_bit,
    output resp_ones,
    output resp_unstable
  );
endinterface

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF sequencer: holds a challenge on the delay line, fires NUM_EVALS
// launch pulses, samples the synchronized arbiter after each and votes the result.
module apuf_eval_ctrl #(
  parameter int LINE_LENGTH    = 3,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CAPTURE_CYCLES = 4,
  parameter int NUM_EVALS      = 5,
  parameter int CW             = $clog2(NUM_EVALS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  apuf_eval_ctrl_if.slave        bus,
  output logic [LINE_LENGTH-1:0] challenge_out,
  output logic                   launch,
  input  logic                   arb_in,
  output logic                   busy
);

  localparam int MAX_CYC = (SETTLE_CYCLES > CAPTURE_CYCLES) ? SETTLE_CYCLES : CAPTURE_CYCLES;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_n;
  logic [CYC_W-1:0]       cyc_cnt;
  logic [CW-1:0]          eval_cnt;
  logic [CW-1:0]          ones_cnt;
  logic                   arb_p0;
  logic                   arb_p1;
  logic                   launch_r;
  logic [LINE_LENGTH-1:0] challenge_r;
  logic                   resp_bit_r;
  logic [CW-1:0]          resp_ones_r;
  logic                   resp_unstable_r;
  logic                   accept;
  logic                   settle_last;
  logic                   capture_last;
  logic                   last_eval;

  function automatic logic maj_vote(input logic [CW-1:0] ones);
    return ones > CW'(NUM_EVALS / 2);
  endfunction

  function automatic logic is_unstable(input logic [CW-1:0] ones);
    return (ones != '0) && (ones != CW'(NUM_EVALS));
  endfunction

  assign accept       = (state_r == IDLE) && bus.chal_valid;
  assign settle_last  = (cyc_cnt == CYC_W'(SETTLE_CYCLES - 1));
  assign capture_last = (cyc_cnt == CYC_W'(CAPTURE_CYCLES - 1));
  assign last_eval    = (eval_cnt == CW'(NUM_EVALS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:    if (bus.chal_valid) state_n = SETTLE;
      SETTLE:  if (settle_last)    state_n = HIGH;
      HIGH:    if (capture_last)   state_n = LOW;
      LOW:     if (settle_last)    state_n = last_eval ? DONE : HIGH;
      DONE:    if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.chal_ready = (state_r == IDLE);
    busy           = (state_r != IDLE);
    bus.resp_valid = (state_r == DONE);
  end

  // Stage p0/p1: two-flop synchronizer for the asynchronous arbiter latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_p0 <= 1'b0;
      arb_p1 <= 1'b0;
    end else begin
      arb_p0 <= arb_in;
      arb_p1 <= arb_p0;
    end
  end

  // Phase timer restarts on every state change so each phase counts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (state_n != state_r) begin
      cyc_cnt <= '0;
    end else if (state_r == SETTLE || state_r == HIGH || state_r == LOW) begin
      cyc_cnt <= cyc_cnt + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_cnt <= '0;
      ones_cnt <= '0;
    end else if (accept) begin
      eval_cnt <= '0;
      ones_cnt <= '0;
    end else begin
      if (state_r == HIGH && capture_last) ones_cnt <= ones_cnt + CW'(arb_p1);
      if (state_r == LOW && settle_last)   eval_cnt <= eval_cnt + CW'(1);
    end
  end

  // Launch is a pure flop output, decoded from the next state so it tracks HIGH exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) launch_r <= 1'b0;
    else     launch_r <= (state_n == HIGH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         challenge_r <= '0;
    else if (accept) challenge_r <= bus.chal_in;
  end

  // Response registers load once on entry to DONE and then hold through IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_bit_r      <= 1'b0;
      resp_ones_r     <= '0;
      resp_unstable_r <= 1'b0;
    end else if (state_r == LOW && state_n == DONE) begin
      resp_bit_r      <= maj_vote(ones_cnt);
      resp_ones_r     <= ones_cnt;
      resp_unstable_r <= is_unstable(ones_cnt);
    end
  end

  assign launch            = launch_r;
  assign challenge_out     = challenge_r;
  assign bus.resp_bit      = resp_bit_r;
  assign bus.resp_ones     = resp_ones_r;
  assign bus.resp_unstable = resp_unstable_r;

endmodule
